systolic_out_streamer: RTL and testbench
========================================

// Module: systolic_out_streamer
// PURPOSE
//  Snapshot a finished ROWS x COLS result tile from the systolic array into a local buffer.
//  Stream the buffer out as one AXI-style write-data burst, with valid/ready/last handshake.
//  Sits between the array result registers and the AXI write master.
//  Successor of the fixed 8x8 output transform: parametrised, double-mode (FP32/FP16 packing),
//  and handshaked, with per-row release tracking.
// PARAMETERS
//  ROWS   8    tile rows; must be even and >= 2
//  COLS   8    tile columns
//  DW     32   element width in the array, in bits
//  BUS_W  256  write-data width; must equal COLS*DW
// PORTS
//  clk           in   1               clock; all state on rising edge
//  rst_n         in   1               asynchronous, active-low reset
//  tile_valid    in   1               array presents a complete tile on tile_data
//  tile_ready    out  1               buffer free; capture occurs on tile_valid&&tile_ready
//  tile_fp16     in   1               sampled at capture: 1 = pack low 16b of each element
//  tile_data     in   ROWS*COLS*DW    row r, col c at bits [(r*COLS+c)*DW +: DW]
//  burst_len     out  32              beats-1 of the current/next burst (AXI awlen style)
//  w_valid       out  1               write beat valid
//  w_ready       in   1               downstream accepts beat
//  w_data        out  BUS_W           beat payload
//  w_last        out  1               final beat of the burst
//  row_released  out  ROWS            bit r set once row r has been fully sent
//  beat_ptr      out  $clog2(ROWS)    index of the beat currently presented
//  tile_done     out  1               1-cycle pulse after the last beat handshake
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State IDLE. tile_ready=1. w_valid=0, w_last=0, w_data=0.
//   - beat_ptr=0, row_released=0, tile_done=0, burst_len=ROWS-1.
//  State machine, states IDLE and STREAM
//   - IDLE: tile_ready=1, w_valid=0. On tile_valid:
//     - copy tile_data to the buffer.
//     - latch mode<=tile_fp16.
//     - beat_ptr<=0, row_released<=0.
//     - go to STREAM next cycle. Capture-to-first-w_valid latency is 1 cycle.
//   - STREAM: tile_ready=0, w_valid=1. tile_valid is ignored; the array must hold.
//  Beats per tile
//   - NB = ROWS when mode=0, ROWS/2 when mode=1.
//   - burst_len = NB-1, driven from the latched mode while in STREAM.
//   - In IDLE, burst_len is driven from the live tile_fp16.
//  Beat payload, where p = beat_ptr
//   - mode=0: w_data = row p, i.e. element c of row p at bits [c*DW +: DW].
//   - mode=1: w_data[c*16 +: 16] = row 2p, element c, bits [15:0].
//     w_data[(COLS+c)*16 +: 16] = row 2p+1, element c, bits [15:0].
//     Remaining upper bits are 0.
//  Stepping
//   - w_last = (beat_ptr==NB-1) && w_valid.
//   - Handshake is w_valid && w_ready. On each handshake:
//     - mode=0: set row_released[p].
//     - mode=1: set row_released[2p] and row_released[2p+1].
//     - if not last: beat_ptr++.
//     - if last: beat_ptr<=0, go to IDLE, tile_done=1 for exactly one cycle.
//   - row_released holds its value in IDLE until the next capture clears it.
//  Flow control and edge cases
//   - w_ready=0: w_data, w_last and beat_ptr hold steady. Beats may not be dropped or repeated.
//   - w_ready may be held high continuously; then one beat transfers per cycle.
//   - New capture is possible in the cycle after tile_done. No same-cycle overlap; simplicity wins.
//   - Reset asserted mid-burst: immediately returns to the reset state and the partial burst is abandoned.
//   - w_valid, once high, stays high until its handshake; this is the AXI rule.
//   - The buffer is the only large storage, ROWS*COLS*DW flops.
//   - The output mux is indexed by beat_ptr; no combinational path from tile_data to w_data.
// TESTING
//  T1 Reset
//   - Stimulus: rst_n=0 mid-STREAM at beat 3.
//   - Required: w_valid=0, tile_ready=1 and row_released=0 asynchronously.
//     beat_ptr=0 after release.
//  T2 FP32 burst, defaults
//   - Stimulus: element(r,c)=r*16+c, w_ready=1.
//   - Required: 8 beats on consecutive cycles. Beat 2 word 5 = 0x25.
//     w_last only on beat 7. burst_len=7. tile_done 1 cycle after beat 7.
//  T3 FP16 burst
//   - Stimulus: element(r,c)=0xABCD0000|(r<<4|c).
//   - Required: 4 beats, burst_len=3. Beat 1 halfword 0 = 0x0020, halfword 8 = 0x0030.
//     Upper 16 bits are dropped.
//  T4 Backpressure
//   - Stimulus: w_ready toggles 1,0,0,1,... randomly.
//   - Required: every row is sent exactly once, in order. Outputs are stable while w_ready=0.
//     row_released tracks accepted beats, e.g. 0x0F after 4 FP32 beats.
//  T5 Busy ignore
//   - Stimulus: tile_valid held high with new data during STREAM.
//   - Required: no recapture, and the old tile is sent intact.
//     Second tile captured in the cycle after tile_done.
//  T6 Parametric
//   - Stimulus: ROWS=4, COLS=4, DW=32, BUS_W=128, in both modes.
//   - Required: NB=4 in FP32 mode and NB=2 in FP16 mode. The same checks as T2 and T3 pass.

Source files
------------

// File: rtl/systolic_out_streamer.sv
// systolic_out_streamer: snapshot a result tile and stream it out as one
// valid/ready/last write burst of FP32 rows or packed FP16 row pairs.
module systolic_out_streamer #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DW    = 32,
  parameter int BUS_W = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tile_valid,
  output logic                    tile_ready,
  input  logic                    tile_fp16,
  input  logic [ROWS*COLS*DW-1:0] tile_data,
  output logic [31:0]             burst_len,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [BUS_W-1:0]        w_data,
  output logic                    w_last,
  output logic [ROWS-1:0]         row_released,
  output logic [$clog2(ROWS)-1:0] beat_ptr,
  output logic                    tile_done
);
  localparam int PW = $clog2(ROWS);
  localparam logic [PW-1:0] LAST32 = PW'(ROWS - 1);
  localparam logic [PW-1:0] LAST16 = PW'(ROWS / 2 - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  st;
  logic                    mode;
  logic [ROWS*COLS*DW-1:0] tile_q;
  logic [PW-1:0]           last_ptr;
  logic [ROWS-1:0]         rel_mask;
  logic                    cap;
  logic                    hs;

  assign cap      = (st == IDLE) && tile_valid;
  assign hs       = w_valid && w_ready;
  assign last_ptr = mode ? LAST16 : LAST32;
  assign w_last   = w_valid && (beat_ptr == last_ptr);

  // beats-1: latched mode while streaming, live mode when idle
  always_comb begin
    if (st == STREAM)
      burst_len = 32'(mode ? ROWS / 2 - 1 : ROWS - 1);
    else
      burst_len = 32'(tile_fp16 ? ROWS / 2 - 1 : ROWS - 1);
  end

  // rows covered by the beat currently presented
  always_comb begin
    rel_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (mode)
        rel_mask[r] = ((r / 2) == int'(beat_ptr));
      else
        rel_mask[r] = (r == int'(beat_ptr));
    end
  end

  // beat payload muxed from the snapshot; FP16 packs a row pair
  always_comb begin
    w_data = '0;
    if (w_valid) begin
      if (!mode) begin
        for (int c = 0; c < COLS; c++)
          w_data[c*DW +: DW] =
            tile_q[(int'(beat_ptr)*COLS + c)*DW +: DW];
      end else begin
        for (int c = 0; c < COLS; c++) begin
          w_data[c*16 +: 16] =
            tile_q[(2*int'(beat_ptr)*COLS + c)*DW +: 16];
          w_data[(COLS+c)*16 +: 16] =
            tile_q[((2*int'(beat_ptr)+1)*COLS + c)*DW +: 16];
        end
      end
    end
  end

  // tile snapshot; pure payload, qualified by w_valid downstream
  always_ff @(posedge clk) begin
    if (cap)
      tile_q <= tile_data;
  end

  // capture / stream control with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      tile_ready   <= 1'b1;
      w_valid      <= 1'b0;
      mode         <= 1'b0;
      beat_ptr     <= '0;
      row_released <= '0;
      tile_done    <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (tile_valid) begin
            mode         <= tile_fp16;
            beat_ptr     <= '0;
            row_released <= '0;
            tile_ready   <= 1'b0;
            w_valid      <= 1'b1;
            st           <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            row_released <= row_released | rel_mask;
            if (w_last) begin
              beat_ptr   <= '0;
              tile_ready <= 1'b1;
              w_valid    <= 1'b0;
              tile_done  <= 1'b1;
              st         <= IDLE;
            end else begin
              beat_ptr <= beat_ptr + 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_out_streamer.sv
// tb_systolic_out_streamer: table-driven bursts for an 8x8 and a 4x4
// instance against a row/column model, plus reset and busy sequences.
module tb_systolic_out_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tv, fp, wr, sel;
  int   total = 0;
  int   bad   = 0;

  logic          tv8, tr8, wv8, wl8, done8;
  logic [2047:0] td8;
  logic [31:0]   bl8;
  logic [255:0]  wd8;
  logic [7:0]    rr8;
  logic [2:0]    bp8;

  logic          tv4, tr4, wv4, wl4, done4;
  logic [511:0]  td4;
  logic [31:0]   bl4;
  logic [127:0]  wd4;
  logic [3:0]    rr4;
  logic [1:0]    bp4;

  logic          tr, wv, wl, done;
  logic [31:0]   bl;
  logic [255:0]  wd;
  logic [7:0]    rr;
  logic [2:0]    bp;

  assign tv8  = tv & ~sel;
  assign tv4  = tv & sel;
  assign tr   = sel ? tr4 : tr8;
  assign wv   = sel ? wv4 : wv8;
  assign wl   = sel ? wl4 : wl8;
  assign done = sel ? done4 : done8;
  assign bl   = sel ? bl4 : bl8;
  assign wd   = sel ? {128'b0, wd4} : wd8;
  assign rr   = sel ? {4'b0, rr4} : rr8;
  assign bp   = sel ? {1'b0, bp4} : bp8;

  systolic_out_streamer u8 (
    .clk(clk), .rst_n(rst_n),
    .tile_valid(tv8), .tile_ready(tr8),
    .tile_fp16(fp), .tile_data(td8),
    .burst_len(bl8), .w_valid(wv8),
    .w_ready(wr), .w_data(wd8),
    .w_last(wl8), .row_released(rr8),
    .beat_ptr(bp8), .tile_done(done8)
  );

  systolic_out_streamer #(
    .ROWS(4), .COLS(4), .DW(32), .BUS_W(128)
  ) u4 (
    .clk(clk), .rst_n(rst_n),
    .tile_valid(tv4), .tile_ready(tr4),
    .tile_fp16(fp), .tile_data(td4),
    .burst_len(bl4), .w_valid(wv4),
    .w_ready(wr), .w_data(wd4),
    .w_last(wl4), .row_released(rr4),
    .beat_ptr(bp4), .tile_done(done4)
  );

  typedef struct {
    int rows;
    bit fp16;
    int kind;
    bit rnd;
    int exp_bl;
    int exp_nb;
  } vec_t;

  vec_t         tbl[8];
  logic [31:0]  el[8][8];
  logic [31:0]  ref_el[8][8];
  logic [255:0] got[$];

  task automatic chk(input string nm, input logic [255:0] a,
                     input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic load(input int R, input int kind);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < R; c++) begin
        if (kind == 0)
          el[r][c] = 32'(r * 16 + c);
        else if (kind == 1)
          el[r][c] = 32'hABCD0000 | 32'((r << 4) | c);
        else
          el[r][c] = $urandom;
      end
  endtask

  task automatic pack(input int R);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < R; c++) begin
        if (R == 8)
          td8[(r*8+c)*32 +: 32] = el[r][c];
        else
          td4[(r*4+c)*32 +: 32] = el[r][c];
      end
  endtask

  function automatic logic [255:0] model(input int R, input int k,
                                         input bit m);
    logic [255:0] v;
    v = '0;
    for (int c = 0; c < R; c++) begin
      if (!m) begin
        v[c*32 +: 32] = ref_el[k][c];
      end else begin
        v[c*16 +: 16]     = ref_el[2*k][c][15:0];
        v[(R+c)*16 +: 16] = ref_el[2*k+1][c][15:0];
      end
    end
    return v;
  endfunction

  task automatic run(input int R, input bit m, input int kind,
                     input bit rnd, input int ebl, input int enb,
                     input bit busy);
    int k, cyc, rpb;
    rpb = m ? 2 : 1;
    sel = (R == 4);
    load(R, kind);
    pack(R);
    ref_el = el;
    fp = m;
    wr = 1'b0;
    @(negedge clk);
    chk("idle_ready", tr, 1);
    chk("idle_burst_len", bl, ebl);
    tv = 1'b1;
    @(negedge clk);
    if (busy) begin
      load(R, 2);
      pack(R);
    end else begin
      tv = 1'b0;
    end
    chk("first_valid", wv, 1);
    got.delete();
    k = 0;
    cyc = 0;
    while (k < enb && cyc < 400) begin
      chk("beat_ptr", bp, k);
      chk("w_data", wd, model(R, k, m));
      chk("w_last", wl, k == enb - 1);
      chk("burst_len", bl, ebl);
      chk("w_valid", wv, 1);
      chk("busy_ready", tr, 0);
      chk("row_released", rr, (1 << (k * rpb)) - 1);
      chk("done_early", done, 0);
      wr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr) got.push_back(wd);
      @(negedge clk);
      if (wr) k++;
      cyc++;
    end
    wr = 1'b0;
    chk("beats_sent", k, enb);
    chk("tile_done", done, 1);
    chk("end_valid", wv, 0);
    chk("end_ready", tr, 1);
    chk("end_released", rr, (1 << R) - 1);
    chk("end_ptr", bp, 0);
    chk("end_last", wl, 0);
    if (busy) begin
      ref_el = el;
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("recapture", wv, 1);
      chk("second_beat0", wd, model(R, 0, m));
      tv = 1'b0;
      wr = 1'b1;
      cyc = 0;
      while (!done && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk("second_drain", done, 1);
      wr = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic reset_mid();
    sel = 1'b0;
    load(8, 2);
    pack(8);
    ref_el = el;
    fp = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    tv = 1'b1;
    @(negedge clk);
    tv = 1'b0;
    wr = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_ptr", bp, 3);
    chk("pre_rst_rel", rr, 8'h07);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", wv, 0);
    chk("rst_ready", tr, 1);
    chk("rst_released", rr, 0);
    chk("rst_ptr", bp, 0);
    chk("rst_last", wl, 0);
    chk("rst_data", wd, 0);
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ptr", bp, 0);
    chk("post_rst_valid", wv, 0);
    chk("post_rst_bl", bl, 7);
  endtask

  initial begin
    logic [255:0] b;
    rst_n = 1'b0;
    tv = 1'b0;
    fp = 1'b0;
    wr = 1'b0;
    sel = 1'b0;
    td8 = '0;
    td4 = '0;
    tbl[0] = '{8, 1'b0, 0, 1'b0, 7, 8};
    tbl[1] = '{8, 1'b1, 1, 1'b0, 3, 4};
    tbl[2] = '{8, 1'b0, 2, 1'b1, 7, 8};
    tbl[3] = '{8, 1'b1, 2, 1'b1, 3, 4};
    tbl[4] = '{4, 1'b0, 0, 1'b0, 3, 4};
    tbl[5] = '{4, 1'b1, 1, 1'b0, 1, 2};
    tbl[6] = '{4, 1'b0, 2, 1'b1, 3, 4};
    tbl[7] = '{4, 1'b1, 2, 1'b1, 1, 2};
    #12;
    chk("reset_ready", tr, 1);
    chk("reset_valid", wv, 0);
    chk("reset_last", wl, 0);
    chk("reset_data", wd, 0);
    chk("reset_ptr", bp, 0);
    chk("reset_released", rr, 0);
    chk("reset_done", done, 0);
    chk("reset_bl", bl, 7);
    sel = 1'b1;
    #1;
    chk("reset_bl4", bl, 3);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].rows, tbl[i].fp16, tbl[i].kind, tbl[i].rnd,
          tbl[i].exp_bl, tbl[i].exp_nb, 1'b0);
      if (i == 0) begin
        b = got[2];
        chk("t2_beat2_word5", b[191:160], 32'h25);
      end
      if (i == 1) begin
        b = got[1];
        chk("t3_beat1_hw0", b[15:0], 16'h0020);
        chk("t3_beat1_hw8", b[143:128], 16'h0030);
      end
    end
    run(8, 1'b0, 0, 1'b0, 7, 8, 1'b1);
    run(4, 1'b1, 2, 1'b1, 1, 2, 1'b1);
    reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
